// File: rtl/pipe_mem_arbiter_pkg.sv
// Shared types and defaults for the pipeline data-memory arbiter.
package pipe_mem_arbiter_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam int unsigned STARVE_LIMIT_DEF = 4;
    localparam int unsigned LOCK_MAX_DEF     = 8;
    localparam int unsigned DATA_W           = 32;
    localparam int unsigned CNT_W            = 16;

endpackage

// File: rtl/pipe_mem_arbiter_sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16
    import pipe_mem_arbiter_pkg::*;
(
    input  logic             clock,
    input  logic             resetn,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_mem_arbiter.sv
// Arbitrates the single data-RAM port between the MEM stage and an external
// master, with starvation forcing and bounded locked bursts.
module pipe_mem_arbiter
    import pipe_mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int unsigned LOCK_MAX     = LOCK_MAX_DEF
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic              ext_lock,
    input  logic [DATA_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 2);
    localparam int unsigned LW = $clog2(LOCK_MAX + 2);

    arb_state_t    state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [LW-1:0] lock_q, lock_d, lock_inc;
    logic          force_cpu_q, force_cpu_d;
    logic          starved;
    logic          cpu_owns;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ARB;
            starve_q    <= '0;
            lock_q      <= '0;
            force_cpu_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            lock_q      <= lock_d;
            force_cpu_q <= force_cpu_d;
        end
    end

    // Grant decision and burst tracking; grants are suppressed while in reset.
    always_comb begin
        state_d     = state_q;
        lock_d      = lock_q;
        force_cpu_d = 1'b0;
        ext_gnt     = 1'b0;
        starved     = (starve_q == SW'(STARVE_LIMIT));
        lock_inc    = lock_q + LW'(1);

        case (state_q)
            ARB: begin
                ext_gnt = resetn & ext_req & (~cpu_req | (starved & ~force_cpu_q));
                if (ext_gnt && ext_lock) begin
                    if (LW'(LOCK_MAX) == LW'(1)) begin
                        force_cpu_d = 1'b1;
                    end else begin
                        state_d = LOCK;
                        lock_d  = LW'(1);
                    end
                end
            end
            LOCK: begin
                ext_gnt = resetn & ext_req;
                if (!ext_gnt) begin
                    state_d = ARB;
                    lock_d  = '0;
                end else if (lock_inc == LW'(LOCK_MAX)) begin
                    // Burst exhausted: the CPU gets the very next slot.
                    state_d     = ARB;
                    lock_d      = '0;
                    force_cpu_d = 1'b1;
                end else if (!ext_lock) begin
                    state_d = ARB;
                    lock_d  = '0;
                end else begin
                    lock_d = lock_inc;
                end
            end
            default: begin
                state_d = ARB;
                lock_d  = '0;
            end
        endcase

        starve_d = '0;
        if (ext_req && !ext_gnt) begin
            starve_d = starved ? starve_q : starve_q + SW'(1);
        end
    end

    // RAM port steering; the CPU is the default owner when nothing is granted.
    always_comb begin
        cpu_owns  = cpu_req & ~ext_gnt;
        cpu_stall = cpu_req & ext_gnt;
        mem_we    = ext_gnt ? ext_we : (cpu_req & cpu_we);
        mem_addr  = ext_gnt ? ext_addr : cpu_addr;
        mem_wdata = ext_gnt ? ext_wdata : cpu_wdata;
        cpu_rdata = cpu_owns ? mem_rdata : '0;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ext_rvalid <= 1'b0;
            ext_rdata  <= '0;
        end else begin
            ext_rvalid <= ext_gnt & ~ext_we;
            if (ext_gnt && !ext_we) begin
                ext_rdata <= mem_rdata;
            end
        end
    end

    sat_counter16 u_stall_cnt (
        .clock  (clock),
        .resetn (resetn),
        .inc    (cpu_stall),
        .count  (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Self-checking bench for pipe_mem_arbiter: directed scenarios plus a random
// run against a cycle-level behavioural model of the arbitration rules.
module tb_pipe_mem_arbiter;

    localparam int SL = 4;
    localparam int LM = 8;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        resetn;
    logic        cpu_req, cpu_we, cpu_stall;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        ext_req, ext_we, ext_lock, ext_gnt, ext_rvalid;
    logic [31:0] ext_addr, ext_wdata, ext_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [15:0] stall_cnt;

    logic [31:0] ram [256];

    always @(negedge clock) if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
    assign mem_rdata = ram[mem_addr[7:0]];

    pipe_mem_arbiter u_dut (
        .clock(clock), .resetn(resetn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_cnt(stall_cnt)
    );

    // Second instance with a very long burst limit, used only to saturate the counter.
    logic        s_resetn, s_cpu_req, s_cpu_we, s_cpu_stall;
    logic [31:0] s_cpu_addr, s_cpu_wdata, s_cpu_rdata;
    logic        s_ext_req, s_ext_we, s_ext_lock, s_ext_gnt, s_ext_rvalid;
    logic [31:0] s_ext_addr, s_ext_wdata, s_ext_rdata;
    logic        s_mem_we;
    logic [31:0] s_mem_addr, s_mem_wdata, s_mem_rdata;
    logic [15:0] s_stall_cnt;

    assign s_mem_rdata = s_mem_addr;

    pipe_mem_arbiter #(.STARVE_LIMIT(4), .LOCK_MAX(100000)) u_sat (
        .clock(clock), .resetn(s_resetn),
        .cpu_req(s_cpu_req), .cpu_we(s_cpu_we), .cpu_addr(s_cpu_addr), .cpu_wdata(s_cpu_wdata),
        .cpu_rdata(s_cpu_rdata), .cpu_stall(s_cpu_stall),
        .ext_req(s_ext_req), .ext_we(s_ext_we), .ext_lock(s_ext_lock), .ext_addr(s_ext_addr),
        .ext_wdata(s_ext_wdata), .ext_gnt(s_ext_gnt), .ext_rvalid(s_ext_rvalid),
        .ext_rdata(s_ext_rdata), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
        .mem_wdata(s_mem_wdata), .mem_rdata(s_mem_rdata), .stall_cnt(s_stall_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int          waited;
    int          burst_len;
    bit          owed;
    bit          e_gnt, e_stall, e_mem_we, e_rvalid;
    logic [31:0] e_cpu_rdata, e_mem_addr, e_mem_wdata, e_rdata;
    int          e_stall_cnt;
    logic [31:0] shadow [256];

    function automatic logic [31:0] ram_init(input int i);
        return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
    endfunction

    // Expected combinational outputs for the current inputs and model state.
    task automatic model_comb();
        e_gnt       = resetn && ext_req && (burst_len > 0 || !cpu_req || (waited == SL && !owed));
        e_stall     = cpu_req && e_gnt;
        e_mem_we    = e_gnt ? ext_we : (cpu_req && cpu_we);
        e_mem_addr  = e_gnt ? ext_addr : cpu_addr;
        e_mem_wdata = e_gnt ? ext_wdata : cpu_wdata;
        e_cpu_rdata = (cpu_req && !e_gnt) ? shadow[cpu_addr[7:0]] : 32'h0;
    endtask

    // Advance the model by one clock edge.
    task automatic model_commit();
        bit new_owed;
        if (e_mem_we) shadow[e_mem_addr[7:0]] = e_mem_wdata;
        if (!resetn) begin
            waited = 0; burst_len = 0; owed = 0;
            e_rvalid = 0; e_rdata = 32'h0; e_stall_cnt = 0;
            return;
        end
        e_rvalid = e_gnt && !ext_we;
        if (e_rvalid) e_rdata = shadow[ext_addr[7:0]];
        if (e_stall && e_stall_cnt < 65535) e_stall_cnt++;
        new_owed = 0;
        if (burst_len > 0) begin
            if (!e_gnt) burst_len = 0;
            else begin
                burst_len++;
                if (burst_len == LM) begin burst_len = 0; new_owed = 1; end
                else if (!ext_lock) burst_len = 0;
            end
        end else if (e_gnt && ext_lock) begin
            burst_len = 1;
        end
        waited = (ext_req && !e_gnt) ? ((waited < SL) ? waited + 1 : SL) : 0;
        owed = new_owed;
    endtask

    task automatic drive(input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                         input bit er, input bit ew, input bit el,
                         input logic [31:0] ea, input logic [31:0] ed);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        ext_req = er; ext_we = ew; ext_lock = el; ext_addr = ea; ext_wdata = ed;
        #1;
        model_comb();
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        model_commit();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        resetn = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        drive(0, 0, 0, 0, 1, 0, 0, 32'h5, 0);
        checks++;
        if (ext_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got %b want 0", ext_gnt); end
        tick();
        checks++;
        if (ext_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b want 0", ext_rvalid); end
        checks++;
        if (ext_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", ext_rdata); end
        checks++;
        if (stall_cnt !== 16'h0) begin errors++; $display("FAIL reset_stall_cnt got %h want 0", stall_cnt); end
        resetn = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_cpu_store();
        do_reset();
        drive(1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
        checks++;
        if (mem_we !== 1'b1) begin errors++; $display("FAIL store_mem_we got %b want 1", mem_we); end
        checks++;
        if (cpu_stall !== 1'b0) begin errors++; $display("FAIL store_stall got %b want 0", cpu_stall); end
        checks++;
        if (mem_addr !== 32'h10 || mem_wdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL store_port got %h/%h want 00000010/deadbeef", mem_addr, mem_wdata);
        end
        tick();
        checks++;
        if (stall_cnt !== 16'h0) begin errors++; $display("FAIL store_stall_cnt got %h want 0", stall_cnt); end
        drive(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
        checks++;
        if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_back got %h want deadbeef", cpu_rdata); end
        tick();
    endtask

    task automatic test_ext_read();
        do_reset();
        drive(0, 0, 0, 0, 1, 0, 0, 32'h20, 0);
        checks++;
        if (ext_gnt !== 1'b1) begin errors++; $display("FAIL ext_read_gnt got %b want 1", ext_gnt); end
        tick();
        checks++;
        if (ext_rvalid !== 1'b1 || ext_rdata !== ram_init(32'h20)) begin
            errors++; $display("FAIL ext_read_resp got %b/%h want 1/%h", ext_rvalid, ext_rdata, ram_init(32'h20));
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if (ext_rvalid !== 1'b0 || ext_rdata !== ram_init(32'h20)) begin
            errors++; $display("FAIL ext_read_hold got %b/%h want 0/%h", ext_rvalid, ext_rdata, ram_init(32'h20));
        end
    endtask

    task automatic test_starvation();
        do_reset();
        for (int c = 1; c <= 5; c++) begin
            drive(1, 0, 32'h30, 0, 1, 0, 0, 32'h40, 0);
            checks++;
            if (ext_gnt !== (c == 5) || cpu_stall !== (c == 5)) begin
                errors++; $display("FAIL starve_cycle%0d got gnt=%b stall=%b want %b", c, ext_gnt, cpu_stall, c == 5);
            end
            tick();
        end
        checks++;
        if (stall_cnt !== 16'd1) begin errors++; $display("FAIL starve_stall_cnt got %0d want 1", stall_cnt); end
    endtask

    task automatic test_lock();
        do_reset();
        for (int c = 1; c <= 17; c++) begin
            drive(1, 1, 32'h50, 32'(c), 1, 1, 1, 32'h60, 32'hA000 + 32'(c));
            checks++;
            if (ext_gnt !== ((c >= 5 && c <= 12) || c == 17)) begin
                errors++; $display("FAIL lock_cycle%0d got gnt=%b want %b", c, ext_gnt, (c >= 5 && c <= 12) || c == 17);
            end
            if (c == 13) begin
                checks++;
                if (mem_addr !== 32'h50 || mem_we !== 1'b1 || cpu_stall !== 1'b0) begin
                    errors++; $display("FAIL lock_forced_cpu got addr=%h we=%b stall=%b want 00000050/1/0",
                                       mem_addr, mem_we, cpu_stall);
                end
            end
            tick();
        end
        checks++;
        if (stall_cnt !== 16'd9) begin errors++; $display("FAIL lock_stall_cnt got %0d want 9", stall_cnt); end
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 0, 0, 1, 0, 1, 32'h70, 0);
            tick();
        end
        drive(1, 0, 32'h74, 0, 1, 0, 1, 32'h70, 0);
        checks++;
        if (ext_gnt !== 1'b1) begin errors++; $display("FAIL midlock_gnt got %b want 1", ext_gnt); end
        resetn = 1'b0;
        drive(1, 0, 32'h74, 0, 1, 0, 1, 32'h70, 0);
        checks++;
        if (ext_gnt !== 1'b0) begin errors++; $display("FAIL midlock_abort got %b want 0", ext_gnt); end
        checks++;
        if (ext_rvalid !== 1'b0 || ext_rdata !== 32'h0 || stall_cnt !== 16'h0) begin
            errors++; $display("FAIL midlock_regs got %b/%h/%h want 0/0/0", ext_rvalid, ext_rdata, stall_cnt);
        end
        tick();
        resetn = 1'b1;
        drive(1, 0, 32'h74, 0, 1, 0, 1, 32'h70, 0);
        checks++;
        if (ext_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
            errors++; $display("FAIL midlock_arb got gnt=%b stall=%b want 0/0", ext_gnt, cpu_stall);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            resetn = ($urandom_range(0, 199) != 0);
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, 32'($urandom_range(0, 255)), $urandom,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 5,
                  32'($urandom_range(0, 255)), $urandom);
            checks++;
            if (ext_gnt !== e_gnt || cpu_stall !== e_stall || mem_we !== e_mem_we) begin
                errors++; $display("FAIL rand%0d_ctrl got gnt=%b stall=%b we=%b want %b %b %b",
                                   n, ext_gnt, cpu_stall, mem_we, e_gnt, e_stall, e_mem_we);
            end
            checks++;
            if (cpu_rdata !== e_cpu_rdata) begin
                errors++; $display("FAIL rand%0d_cpu_rdata got %h want %h", n, cpu_rdata, e_cpu_rdata);
            end
            if (e_gnt || cpu_req) begin
                checks++;
                if (mem_addr !== e_mem_addr || mem_wdata !== e_mem_wdata) begin
                    errors++; $display("FAIL rand%0d_port got %h/%h want %h/%h",
                                       n, mem_addr, mem_wdata, e_mem_addr, e_mem_wdata);
                end
            end
            tick();
            checks++;
            if (ext_rvalid !== e_rvalid || ext_rdata !== e_rdata || stall_cnt !== 16'(e_stall_cnt)) begin
                errors++; $display("FAIL rand%0d_regs got %b/%h/%0d want %b/%h/%0d",
                                   n, ext_rvalid, ext_rdata, stall_cnt, e_rvalid, e_rdata, e_stall_cnt);
            end
        end
    endtask

    task automatic test_saturation();
        s_cpu_req = 1'b1; s_ext_req = 1'b1; s_ext_lock = 1'b1; s_ext_we = 1'b1;
        s_resetn = 1'b1;
        repeat (65538) @(posedge clock);
        #1;
        checks++;
        if (s_stall_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got %h want fffe", s_stall_cnt); end
        @(posedge clock); #1;
        checks++;
        if (s_stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got %h want ffff", s_stall_cnt); end
        repeat (4500) @(posedge clock);
        #1;
        checks++;
        if (s_stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h want ffff", s_stall_cnt); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]    = ram_init(i);
            shadow[i] = ram_init(i);
        end
        waited = 0; burst_len = 0; owed = 0;
        e_rvalid = 0; e_rdata = 32'h0; e_stall_cnt = 0;
        s_resetn = 1'b0; s_cpu_req = 1'b0; s_cpu_we = 1'b0; s_cpu_addr = 32'h0; s_cpu_wdata = 32'h0;
        s_ext_req = 1'b0; s_ext_we = 1'b0; s_ext_lock = 1'b0; s_ext_addr = 32'h8; s_ext_wdata = 32'h0;

        test_reset();
        test_cpu_store();
        test_ext_read();
        test_starvation();
        test_lock();
        test_reset_mid_lock();
        test_random();
        test_saturation();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_mem_arbiter.md
PIPE_MEM_ARBITER -- requirements
Module: pipe_mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: max consecutive cycles an external request waits behind the CPU before it is forced through.
REQ-002 Parameter LOCK_MAX, default 8: max consecutive external cycles while ext_lock is held.
REQ-003 Port clock  in  1: single clock; all state updates on its rising edge.
REQ-004 Port resetn  in  1: asynchronous, active-low reset.
REQ-005 Port cpu_req  in  1: MEM stage access this cycle (load or store).
REQ-006 Port cpu_we  in  1: MEM stage store.
REQ-007 Ports cpu_addr, cpu_wdata  in  32: MEM stage address (malu) and store data (mb).
REQ-008 Port cpu_rdata  out  32: load data to MEM stage.
REQ-009 Port cpu_stall  out  1: MEM access not serviced this cycle; the pipeline freezes PC and all pipeline registers.
REQ-010 Ports ext_req, ext_we, ext_lock  in  1: external master (loader/debug) request, write, burst lock.
REQ-011 Ports ext_addr, ext_wdata  in  32: external address and write data.
REQ-012 Port ext_gnt  out  1: external access performed this cycle.
REQ-013 Ports ext_rvalid  out  1, ext_rdata  out  32: registered read response.
REQ-014 Ports mem_we  out  1, mem_addr, mem_wdata  out  32, mem_rdata  in  32: data RAM port, clocked on the inverted clock; read data is valid within the same cycle.
REQ-015 Port stall_cnt  out  16: saturating count of cpu_stall cycles.

Function
REQ-016 FSM states SHALL be ARB and LOCK.
REQ-017 In ARB, ext_gnt SHALL be asserted when ext_req=1 and either cpu_req=0 or starve_cnt==STARVE_LIMIT; otherwise the CPU owns the port.
REQ-018 starve_cnt SHALL increment each cycle that ext_req=1 and ext_gnt=0, and SHALL clear on any ext_gnt or when ext_req=0.
REQ-019 When ext_gnt=1 with ext_lock=1 in ARB, the FSM SHALL enter LOCK with lock_cnt=1.
REQ-020 In LOCK, ext_gnt SHALL equal ext_req, and lock_cnt SHALL increment per granted cycle.
REQ-021 The FSM SHALL return to ARB when ext_lock=0, ext_req=0, or lock_cnt==LOCK_MAX.
REQ-022 On a LOCK_MAX exit, the next ARB cycle SHALL grant the CPU if cpu_req=1, regardless of starve_cnt.
REQ-023 mem_we, mem_addr and mem_wdata SHALL be driven combinationally from the owner's signals.
REQ-024 mem_we SHALL be 0 in any cycle with no grant.
REQ-025 cpu_stall SHALL equal cpu_req & ext_gnt.
REQ-026 cpu_rdata SHALL equal mem_rdata when the CPU owns the port, else 0.
REQ-027 A stalled CPU access SHALL be held stable by the pipeline and serviced on a later cycle; the arbiter holds no CPU state.
REQ-028 ext_rvalid SHALL pulse 1 cycle after a granted read (ext_gnt=1, ext_we=0), with ext_rdata equal to the mem_rdata captured that cycle.
REQ-029 ext_rdata SHALL hold its value otherwise.
REQ-030 stall_cnt SHALL increment on cpu_stall and saturate at 16'hFFFF.

Reset
REQ-031 On resetn=0, asynchronously: FSM=ARB, starve_cnt=0, lock_cnt=0, ext_rvalid=0, ext_rdata=0, stall_cnt=0.
REQ-032 A reset asserted mid-LOCK SHALL abort the burst with no further grant until resetn=1.
REQ-033 Combinational outputs SHALL follow REQ-023 to REQ-026 during reset; the external master re-issues any aborted access.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding and the default STARVE_LIMIT and LOCK_MAX constants.
REQ-035 The saturating stall counter SHALL be one sub-module, sat_counter16.

Verification
REQ-036 Scenario 1 (CPU-only store): cpu_req=1, cpu_we=1, addr=0x10, data=0xDEADBEEF -> mem_we=1, cpu_stall=0, stall_cnt stays 0.
REQ-037 Scenario 2 (external read, idle CPU): ext_req=1, ext_we=0, addr=0x20 -> ext_gnt=1 the same cycle; next cycle ext_rvalid=1 with ext_rdata equal to RAM[0x20].
REQ-038 Scenario 3 (starvation): cpu_req and ext_req held at 1 continuously -> ext_gnt=1 on the 5th cycle only, cpu_stall=1 on that cycle, stall_cnt=1.
REQ-039 Scenario 4 (lock with contention): ext_req=1, ext_lock=1, cpu_req=1, CPU forced through after 4 cycles -> 8 consecutive ext_gnt cycles, then 1 CPU-granted cycle, then arbitration resumes.
REQ-040 Scenario 5 (reset mid-operation): resetn pulsed low at lock_cnt=3 -> ext_gnt=0 immediately, all registers zero, FSM=ARB after release.
REQ-041 Scenario 6 (counter saturation): force 70000 stall cycles -> stall_cnt=16'hFFFF and holds.
